// File: rtl/mb_tx_serializer.sv
// Mainband TX serializer: parallel DATA_WIDTH-bit word to LSB-first serial stream,
// one bit per rising CLK, frames back-to-back while SER_EN is high.
module mb_tx_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  SER_EN,
    output logic                  SER_OUT
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LP_LAST = CW'(DATA_WIDTH - 1);

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-2:0] r_shreg;
    logic                  r_ser_out;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_ser_out <= 1'b0;
        end else if (!SER_EN) begin
            // abort any partial frame; shreg contents are irrelevant until the next load
            r_cnt     <= '0;
            r_ser_out <= 1'b0;
        end else if (r_cnt == '0) begin
            r_ser_out <= P_DATA[0];
            r_shreg   <= P_DATA[DATA_WIDTH-1:1];
            r_cnt     <= CW'(1);
        end else begin
            r_ser_out <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_cnt     <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign SER_OUT = r_ser_out;

endmodule

// File: tb/tb_mb_tx_serializer.sv
// Bench for mb_tx_serializer: per-cycle reference model plus word-level checks
// of single, back-to-back, mid-frame change, abort, wrap and async reset cases.
module tb_mb_tx_serializer;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [DW-1:0] pd;
    logic          en;
    logic          ser_out;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_word;
    int            m_idx;
    logic          m_out;

    mb_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK    (clk),
        .RST    (rst),
        .P_DATA (pd),
        .SER_EN (en),
        .SER_OUT(ser_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the word is latched at the start of each frame and bit m_idx is emitted.
    always @(posedge clk or negedge rst) begin
        if (!rst || !en) begin
            m_out = 1'b0;
            m_idx = 0;
        end else begin
            if (m_idx == 0) m_word = pd;
            m_out = m_word[m_idx];
            m_idx = (m_idx + 1) % DW;
        end
    end

    always @(negedge clk) chk("ser_bit", {31'b0, ser_out}, {31'b0, m_out});

    // Collect one frame; change P_DATA to next_word right after bit chg_at is seen.
    task automatic stream_word(input int chg_at, input logic [DW-1:0] next_word,
                               output logic [DW-1:0] got);
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            got[i] = ser_out;
            if (i == chg_at) pd = next_word;
        end
    endtask

    initial begin
        logic [DW-1:0] rw [0:4];
        logic [DW-1:0] got;
        logic [DW-1:0] mid_a, mid_b;

        for (int k = 0; k < 5; k++) rw[k] = $urandom;
        mid_a = $urandom;
        mid_b = ~mid_a;

        rst = 1'b0; en = 1'b0; pd = '0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_out", {31'b0, ser_out}, '0);
        end
        rst = 1'b1;

        // single word, then four random words back to back
        pd = 32'hA5A5_0F01;
        en = 1'b1;
        stream_word(1, rw[0], got);
        chk("single", got, 32'hA5A5_0F01);
        for (int k = 0; k < 4; k++) begin
            stream_word(1, (k == 3) ? mid_a : rw[k+1], got);
            chk("b2b", got, rw[k]);
        end

        // mid-frame data change after bit 5
        stream_word(5, mid_b, got);
        chk("mid_keep", got, mid_a);
        stream_word(1, rw[4], got);
        chk("mid_next", got, mid_b);

        // enable abort after bit 10
        for (int i = 0; i <= 10; i++) @(negedge clk);
        en = 1'b0;
        pd = 32'h8000_0001;
        repeat (5) begin
            @(negedge clk);
            chk("idle_low", {31'b0, ser_out}, '0);
        end
        en = 1'b1;
        stream_word(1, 32'hFFFF_FFFF, got);
        chk("abort_restart", got, 32'h8000_0001);

        // wrap: three all-ones frames then zeros
        for (int k = 0; k < 3; k++) begin
            stream_word(1, (k == 2) ? 32'h0 : 32'hFFFF_FFFF, got);
            chk("wrap_ones", got, 32'hFFFF_FFFF);
        end
        stream_word(1, 32'hFFFF_FFFF, got);
        chk("wrap_zeros", got, 32'h0);

        // async reset mid-frame while SER_OUT is high
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("pre_async_high", {31'b0, ser_out}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", {31'b0, ser_out}, '0);
        pd = rw[2];
        @(negedge clk);
        chk("reset_hold", {31'b0, ser_out}, '0);
        rst = 1'b1;
        stream_word(1, rw[3], got);
        chk("after_reset", got, rw[2]);

        en = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
